// File: rtl/sseg_pkg.sv
// Shared types and defaults for the 7-segment scan driver.
package sseg_pkg;

    // Active-low segment pattern, dp in bit 7.
    typedef logic [7:0] sseg_t;

    // All segments off.
    localparam sseg_t SSEG_BLANK = 8'hFF;

    localparam int unsigned N_DIGITS_DEF     = 4;
    localparam int unsigned SLOT_LEN_DEF     = 65536;
    localparam int unsigned GUARD_CYCLES_DEF = 64;

endpackage

// File: rtl/scan_timer.sv
// Slot and digit sequencer for the 7-segment scan driver.
// slot_cnt runs 0..SLOT_LEN-1; dig advances on each slot wrap and wraps after the last digit.
module scan_timer import sseg_pkg::*; #(
    parameter int unsigned N_DIGITS = N_DIGITS_DEF,
    parameter int unsigned SLOT_LEN = SLOT_LEN_DEF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic [$clog2(SLOT_LEN)-1:0] slot_cnt_o,
    output logic [$clog2(N_DIGITS)-1:0] dig_o,
    output logic                        slot_start_o,
    output logic                        frame_start_o
);

    localparam int unsigned CntW = $clog2(SLOT_LEN);
    localparam int unsigned DigW = $clog2(N_DIGITS);
    localparam logic [CntW-1:0] CntLast = CntW'(SLOT_LEN - 1);
    localparam logic [DigW-1:0] DigLast = DigW'(N_DIGITS - 1);

    logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
    logic [DigW-1:0] dig_q, dig_d;

    // Next-state: advance slot counter, step digit on slot wrap.
    always_comb begin
        slot_cnt_d = slot_cnt_q + CntW'(1);
        dig_d      = dig_q;
        if (slot_cnt_q == CntLast) begin
            slot_cnt_d = '0;
            dig_d      = (dig_q == DigLast) ? '0 : dig_q + DigW'(1);
        end
    end

    // Counter state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_cnt_q <= '0;
            dig_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_q      <= dig_d;
        end
    end

    assign slot_cnt_o    = slot_cnt_q;
    assign dig_o         = dig_q;
    assign slot_start_o  = (slot_cnt_q == '0);
    assign frame_start_o = (slot_cnt_q == '0) && (dig_q == '0);

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// Optional PWM brightness control is enabled by defining SSEG_SCAN_PWM_EN.
module sseg_scan_mux import sseg_pkg::*; #(
    parameter int unsigned N_DIGITS     = N_DIGITS_DEF,
    parameter int unsigned SLOT_LEN     = SLOT_LEN_DEF,
    parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [8*N_DIGITS-1:0] in_sseg_i,
    input  logic [N_DIGITS-1:0]   blank_i,
`ifdef SSEG_SCAN_PWM_EN
    input  logic [3:0]            duty_i,
`endif
    output logic [N_DIGITS-1:0]   an_o,
    output logic [7:0]            sseg_o,
    output logic                  frame_tick_o
);

    localparam int unsigned CntW = $clog2(SLOT_LEN);
    localparam int unsigned DigW = $clog2(N_DIGITS);
    localparam logic [CntW-1:0] GuardEnd = CntW'(GUARD_CYCLES);

    logic [CntW-1:0]     slot_cnt;
    logic [DigW-1:0]     dig;
    logic                slot_start;
    logic                frame_start;

    sseg_t               pat_q;
    logic                blk_q;
    sseg_t               pat_sel, pat_cur;
    logic                blk_sel, blk_cur;
    logic                in_guard;
    logic                pwm_on;
    logic                lit;

    logic [N_DIGITS-1:0] an_q, an_d;
    sseg_t               sseg_q, sseg_d;
    logic                frame_tick_q;

    scan_timer #(
        .N_DIGITS (N_DIGITS),
        .SLOT_LEN (SLOT_LEN)
    ) u_scan_timer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .slot_cnt_o    (slot_cnt),
        .dig_o         (dig),
        .slot_start_o  (slot_start),
        .frame_start_o (frame_start)
    );

    // Select the current digit's pattern and blank flag from the input buses.
    always_comb begin
        pat_sel = SSEG_BLANK;
        blk_sel = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (dig == DigW'(i)) begin
                pat_sel = in_sseg_i[8*i +: 8];
                blk_sel = blank_i[i];
            end
        end
    end

    // Latch pattern and blank at slot start; held for the rest of the slot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pat_q <= SSEG_BLANK;
            blk_q <= 1'b1;
        end else if (slot_start) begin
            pat_q <= pat_sel;
            blk_q <= blk_sel;
        end
    end

`ifdef SSEG_SCAN_PWM_EN
    logic [3:0] pwm_cnt_q;

    // Free-running brightness counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    assign pwm_on = (pwm_cnt_q <= duty_i);
`else
    assign pwm_on = 1'b1;
`endif

    // The capture register is only loaded at the slot-start edge, so on that cycle use the
    // freshly selected values; this lets GUARD_CYCLES=0 light the first cycle of the slot.
    assign pat_cur  = slot_start ? pat_sel : pat_q;
    assign blk_cur  = slot_start ? blk_sel : blk_q;
    assign in_guard = (slot_cnt < GuardEnd);
    assign lit      = !in_guard && !blk_cur && pwm_on;

    // Output next-state: one active-low anode and the pattern when lit, otherwise all dark.
    always_comb begin
        an_d   = '1;
        sseg_d = SSEG_BLANK;
        if (lit) begin
            an_d   = ~(N_DIGITS'(1) << dig);
            sseg_d = pat_cur;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            an_q         <= '1;
            sseg_q       <= SSEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_start;
        end
    end

    assign an_o         = an_q;
    assign sseg_o       = sseg_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux (4 digits, 8-cycle slots, 2 guard cycles).
// With SSEG_SCAN_PWM_EN defined a second instance exercises the brightness control.
module tb_sseg_scan_mux;

    localparam int NDig    = 4;
    localparam int SlotLen = 8;
    localparam int Guard   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_sseg = 32'hF9A4B0C0;
    logic [3:0]  blank = 4'b0000;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        ft;

    int n_vec = 0;
    int n_err = 0;

    // Position of the output observed after the next step.
    int          cur_pos  = 0;
    int          cur_slot = 0;
    logic [7:0]  cap_seg  = 8'hFF;
    logic        cap_blk  = 1'b1;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_ft;

    logic [3:0] an_tab [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_tab [4] = '{8'hC0, 8'hB0, 8'hA4, 8'hF9};

    always #5 clk = ~clk;

`ifdef SSEG_SCAN_PWM_EN
    logic [3:0]  duty_full = 4'd15;
    logic [3:0]  duty = 4'd3;
    logic [3:0]  blank_p = 4'b0000;
    logic [3:0]  an_p;
    logic [7:0]  sseg_p;
    logic        ft_p;
`endif

    sseg_scan_mux #(
        .N_DIGITS     (NDig),
        .SLOT_LEN     (SlotLen),
        .GUARD_CYCLES (Guard)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_sseg_i    (in_sseg),
        .blank_i      (blank),
`ifdef SSEG_SCAN_PWM_EN
        .duty_i       (duty_full),
`endif
        .an_o         (an),
        .sseg_o       (sseg),
        .frame_tick_o (ft)
    );

`ifdef SSEG_SCAN_PWM_EN
    sseg_scan_mux #(
        .N_DIGITS     (NDig),
        .SLOT_LEN     (64),
        .GUARD_CYCLES (0)
    ) dut_pwm (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_sseg_i    (in_sseg),
        .blank_i      (blank_p),
        .duty_i       (duty),
        .an_o         (an_p),
        .sseg_o       (sseg_p),
        .frame_tick_o (ft_p)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and compute the expected outputs from the captured slot contents.
    task automatic step_model();
        step();
        if (cur_pos == 0) begin
            cap_seg = in_sseg[8*cur_slot +: 8];
            cap_blk = blank[cur_slot];
        end
        exp_ft = (cur_pos == 0) && (cur_slot == 0);
        if (cur_pos >= Guard && !cap_blk) begin
            exp_an  = an_tab[cur_slot];
            exp_seg = cap_seg;
        end else begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end
        cur_pos++;
        if (cur_pos == SlotLen) begin
            cur_pos  = 0;
            cur_slot = (cur_slot + 1) % NDig;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (an !== 4'hF) begin
                n_err++;
                $display("FAIL reset_an[%0d]: got %h expected f", i, an);
            end
            n_vec++;
            if (sseg !== 8'hFF) begin
                n_err++;
                $display("FAIL reset_sseg[%0d]: got %h expected ff", i, sseg);
            end
            n_vec++;
            if (ft !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ft[%0d]: got %b expected 0", i, ft);
            end
        end
        reset = 1'b0;
        n_vec++;
        if (an !== 4'hF || sseg !== 8'hFF || ft !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got an=%h sseg=%h ft=%b expected f/ff/0", an, sseg, ft);
        end
        cur_pos  = 0;
        cur_slot = 0;
    endtask

    // Hand-tabulated scan sequence with constant inputs.
    task automatic test_free_run();
        logic [3:0] e_an;
        logic [7:0] e_seg;
        for (int j = 0; j < 64; j++) begin
            step_model();
            if ((j % 8) >= 2) begin
                e_an  = an_tab[(j / 8) % 4];
                e_seg = seg_tab[(j / 8) % 4];
            end else begin
                e_an  = 4'hF;
                e_seg = 8'hFF;
            end
            n_vec++;
            if (an !== e_an || sseg !== e_seg) begin
                n_err++;
                $display("FAIL free_run[%0d]: got an=%h sseg=%h expected %h/%h",
                         j, an, sseg, e_an, e_seg);
            end
        end
    endtask

    task automatic test_frame_tick();
        int ticks = 0;
        for (int j = 0; j < 64; j++) begin
            step_model();
            if (ft === 1'b1) ticks++;
            n_vec++;
            if (ft !== exp_ft) begin
                n_err++;
                $display("FAIL frame_tick[%0d]: got %b expected %b", j, ft, exp_ft);
            end
        end
        n_vec++;
        if (ticks != 2) begin
            n_err++;
            $display("FAIL frame_tick_count: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_blank();
        blank = 4'b0100;
        for (int j = 0; j < 32; j++) begin
            step_model();
            n_vec++;
            if (an !== exp_an || sseg !== exp_seg) begin
                n_err++;
                $display("FAIL blank[%0d]: got an=%h sseg=%h expected %h/%h",
                         j, an, sseg, exp_an, exp_seg);
            end
        end
        blank = 4'b0000;
        for (int j = 0; j < 32; j++) begin
            step_model();
            n_vec++;
            if (an !== exp_an || sseg !== exp_seg) begin
                n_err++;
                $display("FAIL unblank[%0d]: got an=%h sseg=%h expected %h/%h",
                         j, an, sseg, exp_an, exp_seg);
            end
        end
    endtask

    // Change digit 1 mid-slot: old pattern held to slot end, new one on the next slot.
    task automatic test_hold();
        for (int j = 0; j < 13; j++) begin
            step_model();
            n_vec++;
            if (an !== exp_an || sseg !== exp_seg) begin
                n_err++;
                $display("FAIL hold_pre[%0d]: got an=%h sseg=%h expected %h/%h",
                         j, an, sseg, exp_an, exp_seg);
            end
        end
        in_sseg[15:8] = 8'h92;
        for (int j = 0; j < 35; j++) begin
            step_model();
            n_vec++;
            if (an !== exp_an || sseg !== exp_seg) begin
                n_err++;
                $display("FAIL hold_post[%0d]: got an=%h sseg=%h expected %h/%h",
                         j, an, sseg, exp_an, exp_seg);
            end
            if (j < 3) begin
                n_vec++;
                if (sseg !== 8'hB0) begin
                    n_err++;
                    $display("FAIL hold_old[%0d]: got %h expected b0", j, sseg);
                end
            end
            if (j >= 29) begin
                n_vec++;
                if (sseg !== 8'h92 || an !== 4'hD) begin
                    n_err++;
                    $display("FAIL hold_new[%0d]: got an=%h sseg=%h expected d/92", j, an, sseg);
                end
            end
        end
    endtask

    task automatic test_reset_midslot();
        for (int j = 0; j < 11; j++) step_model();
        reset = 1'b1;
        step();
        n_vec++;
        if (an !== 4'hF || sseg !== 8'hFF || ft !== 1'b0) begin
            n_err++;
            $display("FAIL midslot_reset: got an=%h sseg=%h ft=%b expected f/ff/0", an, sseg, ft);
        end
        reset = 1'b0;
        cur_pos  = 0;
        cur_slot = 0;
        for (int j = 0; j < 16; j++) begin
            step_model();
            n_vec++;
            if (an !== exp_an || sseg !== exp_seg || ft !== exp_ft) begin
                n_err++;
                $display("FAIL midslot_restart[%0d]: got an=%h sseg=%h ft=%b expected %h/%h/%b",
                         j, an, sseg, ft, exp_an, exp_seg, exp_ft);
            end
        end
    endtask

`ifdef SSEG_SCAN_PWM_EN
    task automatic test_pwm();
        int lit_cnt;
        duty    = 4'd3;
        lit_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (an_p !== 4'hF) lit_cnt++;
            n_vec++;
            if ((an_p === 4'hF) !== (sseg_p === 8'hFF) || $countones(~an_p) > 1) begin
                n_err++;
                $display("FAIL pwm3_consistency[%0d]: got an=%h sseg=%h", j, an_p, sseg_p);
            end
        end
        n_vec++;
        if (lit_cnt != 4) begin
            n_err++;
            $display("FAIL pwm3_lit: got %0d lit cycles expected 4", lit_cnt);
        end
        duty    = 4'd15;
        lit_cnt = 0;
        for (int j = 0; j < 64; j++) begin
            step();
            if (an_p !== 4'hF) lit_cnt++;
        end
        n_vec++;
        if (lit_cnt != 64) begin
            n_err++;
            $display("FAIL pwm15_lit: got %0d lit cycles expected 64", lit_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_frame_tick();
        test_blank();
        test_hold();
        test_reset_midslot();
`ifdef SSEG_SCAN_PWM_EN
        test_pwm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
